// File: rtl/tcm_dec_acsu_pipe_pkg.sv
// ---------------------------------------------------------------------------
// tcm_dec_types
//   Shared types and helpers for the TCM decoder add-compare-select path.
//   - statem_t / bm_t   : default-width state / branch metric types
//   - clog2()           : elaboration-time ceil(log2) helper
//   - statem_a_best()   : modulo-arithmetic compare with the tie rule
// ---------------------------------------------------------------------------
package tcm_dec_types;

    localparam int SM_W     = 8;
    localparam int BM_W     = 4;
    localparam int MAX_SM_W = 32;

    typedef logic [SM_W-1:0] statem_t;
    typedef logic [BM_W-1:0] bm_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Returns 1 when operand a wins against b. Metrics live on a circle of
    // 2^sm_w; as long as all live metrics are within half the circle of each
    // other, the sign of (a-b) mod 2^sm_w orders them correctly.
    // On an exact tie (d==0) a wins in both modes; callers always pass the
    // lower-index operand as a.
    function automatic logic statem_a_best(input logic [MAX_SM_W-1:0] a,
                                           input logic [MAX_SM_W-1:0] b,
                                           input int                  sm_w,
                                           input logic                min_mode);
        logic [MAX_SM_W-1:0] mask;
        logic [MAX_SM_W-1:0] d;
        logic                neg;
        logic                zero;
        mask = (sm_w >= MAX_SM_W) ? {MAX_SM_W{1'b1}}
                                  : ((32'd1 << sm_w) - 32'd1);
        d    = (a - b) & mask;
        neg  = |(d & (32'd1 << (sm_w - 1)));
        zero = (d == '0);
        return min_mode ? (neg | zero) : !neg;
    endfunction

endpackage

// File: rtl/tcm_dec_acsu_pipe_cs2.sv
// ---------------------------------------------------------------------------
// tcm_dec_acsu_cs2
//   One combinational compare-select node of the ACS tree.
//   Ports:
//     a_i, b_i          candidate metrics (a is the lower-index operand)
//     idx_a_i, idx_b_i  branch indices carried with each candidate
//     metric_o, idx_o   winning metric and its branch index
// ---------------------------------------------------------------------------
module tcm_dec_acsu_cs2
    import tcm_dec_types::*;
#(
    parameter int pSM_W     = 8,
    parameter int pIDX_W    = 3,
    parameter int pMIN_MODE = 0
) (
    input  logic [pSM_W-1:0]  a_i,
    input  logic [pSM_W-1:0]  b_i,
    input  logic [pIDX_W-1:0] idx_a_i,
    input  logic [pIDX_W-1:0] idx_b_i,
    output logic [pSM_W-1:0]  metric_o,
    output logic [pIDX_W-1:0] idx_o
);

    logic a_wins;

    assign a_wins   = statem_a_best(32'(a_i), 32'(b_i), pSM_W, pMIN_MODE != 0);
    assign metric_o = a_wins ? a_i     : b_i;
    assign idx_o    = a_wins ? idx_a_i : idx_b_i;

endmodule

// File: rtl/tcm_dec_acsu_pipe.sv
// ---------------------------------------------------------------------------
// tcm_dec_acsu_pipe
//   Radix-pN Viterbi add-compare-select node. Adds pN branch metrics to pN
//   predecessor state metrics, then reduces the candidates with a log2(pN)
//   layer compare-select tree. Layer 0 is the adder; layer k (1..log2 pN) is
//   compare layer k. Each layer gets an output register when pPIPE_MASK[k]
//   is set; the final output register always exists.
//
//   Flow control: valid-only streaming. A candidate set is accepted on every
//   edge with iclkena=1, ival=1 and isclr=0. There is no ready; results
//   appear on oval exactly L enabled cycles later and must be consumed then.
//
//   Ports:
//     iclk, ireset      clock, asynchronous active-high reset
//     iclkena           clock enable, freezes all state when low
//     isclr             synchronous flush of every pipeline valid
//     ival/ibm/istatem/itag   input candidate set and sideband tag
//     oval/ostatem/odecision/otag   survivor metric, winning branch, tag
// ---------------------------------------------------------------------------
module tcm_dec_acsu_pipe
    import tcm_dec_types::*;
#(
    parameter int          pN         = 8,
    parameter int          pBM_W      = 4,
    parameter int          pSM_W      = 8,
    parameter logic [31:0] pPIPE_MASK = 32'h1,
    parameter int          pMIN_MODE  = 0,
    parameter int          pTAG_W     = 8
) (
    input  logic                        iclk,
    input  logic                        ireset,
    input  logic                        iclkena,
    input  logic                        isclr,
    input  logic                        ival,
    input  logic [pN-1:0][pBM_W-1:0]    ibm,
    input  logic [pN-1:0][pSM_W-1:0]    istatem,
    input  logic [pTAG_W-1:0]           itag,
    output logic                        oval,
    output logic [pSM_W-1:0]            ostatem,
    output logic [clog2(pN)-1:0]        odecision,
    output logic [pTAG_W-1:0]           otag
);

    localparam int LG = clog2(pN);

    // c_* : combinational result of layer k
    // s_* : layer k result after its optional register
    // Node slots at and above pN>>k are unused in layer k and tied to zero.
    logic [pSM_W-1:0]  c_met [0:LG][0:pN-1];
    logic [LG-1:0]     c_idx [0:LG][0:pN-1];
    logic              c_val [0:LG];
    logic [pTAG_W-1:0] c_tag [0:LG];
    logic [pSM_W-1:0]  s_met [0:LG][0:pN-1];
    logic [LG-1:0]     s_idx [0:LG][0:pN-1];
    logic              s_val [0:LG];
    logic [pTAG_W-1:0] s_tag [0:LG];

    for (genvar k = 0; k <= LG; k++) begin : g_layer
        localparam int NODES = pN >> k;

        for (genvar j = 0; j < pN; j++) begin : g_node
            if (j >= NODES) begin : g_unused
                assign c_met[k][j] = '0;
                assign c_idx[k][j] = '0;
            end else if (k == 0) begin : g_add
                // Plain modulo add: wrap-around is expected, the compare
                // tree is modulo-aware.
                assign c_met[k][j] = {{(pSM_W-pBM_W){1'b0}}, ibm[j]} + istatem[j];
                assign c_idx[k][j] = LG'(j);
            end else begin : g_cs
                tcm_dec_acsu_cs2 #(
                    .pSM_W     (pSM_W),
                    .pIDX_W    (LG),
                    .pMIN_MODE (pMIN_MODE)
                ) u_cs2 (
                    .a_i      (s_met[k-1][2*j]),
                    .b_i      (s_met[k-1][2*j+1]),
                    .idx_a_i  (s_idx[k-1][2*j]),
                    .idx_b_i  (s_idx[k-1][2*j+1]),
                    .metric_o (c_met[k][j]),
                    .idx_o    (c_idx[k][j])
                );
            end
        end

        if (k == 0) begin : g_src_in
            assign c_val[k] = ival;
            assign c_tag[k] = itag;
        end else begin : g_src_prev
            assign c_val[k] = s_val[k-1];
            assign c_tag[k] = s_tag[k-1];
        end

        if (pPIPE_MASK[k]) begin : g_reg
            logic [pSM_W-1:0]  met_q [0:NODES-1];
            logic [LG-1:0]     idx_q [0:NODES-1];
            logic              val_q;
            logic [pTAG_W-1:0] tag_q;

            // Data only moves with a live set, so a flush leaves the data
            // registers untouched and only drops the valid.
            always_ff @(posedge iclk or posedge ireset) begin
                if (ireset) begin
                    val_q <= 1'b0;
                    tag_q <= '0;
                    for (int n = 0; n < NODES; n++) begin
                        met_q[n] <= '0;
                        idx_q[n] <= '0;
                    end
                end else if (iclkena) begin
                    val_q <= c_val[k] & ~isclr;
                    if (c_val[k] && !isclr) begin
                        tag_q <= c_tag[k];
                        for (int n = 0; n < NODES; n++) begin
                            met_q[n] <= c_met[k][n];
                            idx_q[n] <= c_idx[k][n];
                        end
                    end
                end
            end

            for (genvar m = 0; m < pN; m++) begin : g_s
                if (m < NODES) begin : g_used
                    assign s_met[k][m] = met_q[m];
                    assign s_idx[k][m] = idx_q[m];
                end else begin : g_zero
                    assign s_met[k][m] = '0;
                    assign s_idx[k][m] = '0;
                end
            end
            assign s_val[k] = val_q;
            assign s_tag[k] = tag_q;
        end else begin : g_pass
            for (genvar m = 0; m < pN; m++) begin : g_s
                assign s_met[k][m] = c_met[k][m];
                assign s_idx[k][m] = c_idx[k][m];
            end
            assign s_val[k] = c_val[k];
            assign s_tag[k] = c_tag[k];
        end
    end

    // Final output register: holds its contents while no new result arrives.
    logic              out_load;
    logic              oval_q,    oval_d;
    logic [pSM_W-1:0]  ostatem_q, ostatem_d;
    logic [LG-1:0]     odec_q,    odec_d;
    logic [pTAG_W-1:0] otag_q,    otag_d;

    always_comb begin
        out_load  = s_val[LG] & ~isclr;
        oval_d    = out_load;
        ostatem_d = ostatem_q;
        odec_d    = odec_q;
        otag_d    = otag_q;
        if (out_load) begin
            ostatem_d = s_met[LG][0];
            odec_d    = s_idx[LG][0];
            otag_d    = s_tag[LG];
        end
    end

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            oval_q    <= 1'b0;
            ostatem_q <= '0;
            odec_q    <= '0;
            otag_q    <= '0;
        end else if (iclkena) begin
            oval_q    <= oval_d;
            ostatem_q <= ostatem_d;
            odec_q    <= odec_d;
            otag_q    <= otag_d;
        end
    end

    assign oval      = oval_q;
    assign ostatem   = ostatem_q;
    assign odecision = odec_q;
    assign otag      = otag_q;

endmodule

// File: tb/tb_tcm_dec_acsu_pipe.sv
// ---------------------------------------------------------------------------
// tb_tcm_dec_acsu_pipe
//   Ten DUT instances (pN 2..16, mask 0 / all-ones, max and min mode, plus
//   the default configuration) share one stimulus stream. A reference model
//   picks the best candidate as the lowest-index extreme of the signed
//   distances to candidate 0; a per-instance expected queue holds the
//   results with the enabled-edge count at acceptance, so both data and
//   latency are checked.
// ---------------------------------------------------------------------------
module tb_tcm_dec_acsu_pipe;

    localparam int NI = 10;
    localparam int          CFG_N    [NI] = '{8, 4, 2, 2, 4, 4, 8, 8, 16, 16};
    localparam logic [31:0] CFG_MASK [NI] = '{32'h1, 32'h1,
                                              32'h0, 32'hFFFF_FFFF,
                                              32'h0, 32'hFFFF_FFFF,
                                              32'h0, 32'hFFFF_FFFF,
                                              32'h0, 32'hFFFF_FFFF};
    localparam int          CFG_MIN  [NI] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              clkena;
    logic              sclr;
    logic              val;
    logic [15:0][3:0]  bm_v;
    logic [15:0][7:0]  sm_v;
    logic [7:0]        tag_v;

    logic              oval_a [NI];
    logic [7:0]        osm_a  [NI];
    logic [3:0]        odec_a [NI];
    logic [7:0]        otag_a [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int N   = CFG_N[g];
        localparam int LGN = $clog2(N);
        logic [LGN-1:0] dec;

        tcm_dec_acsu_pipe #(
            .pN         (N),
            .pBM_W      (4),
            .pSM_W      (8),
            .pPIPE_MASK (CFG_MASK[g]),
            .pMIN_MODE  (CFG_MIN[g]),
            .pTAG_W     (8)
        ) u_dut (
            .iclk      (clk),
            .ireset    (rst),
            .iclkena   (clkena),
            .isclr     (sclr),
            .ival      (val),
            .ibm       (bm_v[N-1:0]),
            .istatem   (sm_v[N-1:0]),
            .itag      (tag_v),
            .oval      (oval_a[g]),
            .ostatem   (osm_a[g]),
            .odecision (dec),
            .otag      (otag_a[g])
        );

        assign odec_a[g] = 4'(dec);
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Latency = 1 + number of set mask bits in [log2 N : 0].
    function automatic int lat_of(input int g);
        int lg;
        int l;
        lg = 0;
        while ((1 << lg) < CFG_N[g]) lg++;
        l = 1;
        for (int k = 0; k <= lg; k++) if (CFG_MASK[g][k]) l++;
        return l;
    endfunction

    // Each candidate is placed on a signed axis relative to candidate 0;
    // the metric spread guarantees |offset| < 128, so plain integer
    // comparison orders them. Strict comparison keeps the lowest index.
    function automatic void ref_acs(input int n, input int min_mode,
                                    input logic [15:0][3:0] bm,
                                    input logic [15:0][7:0] sm,
                                    output logic [7:0] best,
                                    output logic [3:0] dec);
        logic [7:0] c0;
        logic [7:0] cand;
        logic [7:0] df;
        int         off;
        int         best_off;
        c0       = sm[0] + {4'b0, bm[0]};
        best     = c0;
        dec      = 4'd0;
        best_off = 0;
        for (int i = 1; i < n; i++) begin
            cand = sm[i] + {4'b0, bm[i]};
            df   = cand - c0;
            off  = int'($signed(df));
            if ((min_mode != 0) ? (off < best_off) : (off > best_off)) begin
                best_off = off;
                best     = cand;
                dec      = 4'(i);
            end
        end
    endfunction

    // ---------------- scoreboard ----------------
    // entry: {accept_count[31:0], tag[7:0], dec[3:0], metric[7:0]}
    logic [51:0] exp_q [NI][$];
    int          en_cnt = 0;
    logic        edge_en = 1'b0;
    int          pop_cnt [NI];
    logic        last_oval [NI];
    logic [7:0]  last_sm   [NI];
    logic [3:0]  last_dec  [NI];
    logic [7:0]  last_tag  [NI];

    initial begin
        for (int g = 0; g < NI; g++) begin
            pop_cnt[g]   = 0;
            last_oval[g] = 1'b0;
            last_sm[g]   = '0;
            last_dec[g]  = '0;
            last_tag[g]  = '0;
        end
    end

    always @(posedge clk) begin
        logic [7:0] b;
        logic [3:0] d;
        if (rst) begin
            edge_en = 1'b0;
            for (int g = 0; g < NI; g++) exp_q[g].delete();
        end else if (clkena) begin
            en_cnt++;
            edge_en = 1'b1;
            if (sclr) begin
                for (int g = 0; g < NI; g++) exp_q[g].delete();
            end else if (val) begin
                for (int g = 0; g < NI; g++) begin
                    ref_acs(CFG_N[g], CFG_MIN[g], bm_v, sm_v, b, d);
                    exp_q[g].push_back({32'(en_cnt), tag_v, d, b});
                end
            end
        end else begin
            edge_en = 1'b0;
        end
    end

    always @(negedge clk) begin
        logic [51:0] e;
        logic        exp_v;
        if (rst) begin
            for (int g = 0; g < NI; g++) begin
                last_oval[g] = 1'b0;
                last_sm[g]   = '0;
                last_dec[g]  = '0;
                last_tag[g]  = '0;
            end
        end else begin
            for (int g = 0; g < NI; g++) begin
                if (edge_en) begin
                    exp_v = 1'b0;
                    e     = '0;
                    if (exp_q[g].size() > 0) begin
                        e = exp_q[g][0];
                        if (int'(e[51:20]) + lat_of(g) - 1 <= en_cnt) exp_v = 1'b1;
                    end
                    check_eq($sformatf("i%0d_oval", g), 32'(oval_a[g]), 32'(exp_v));
                    if (exp_v) begin
                        void'(exp_q[g].pop_front());
                        if (oval_a[g]) begin
                            pop_cnt[g]++;
                            check_eq($sformatf("i%0d_statem", g), 32'(osm_a[g]),  32'(e[7:0]));
                            check_eq($sformatf("i%0d_dec", g),    32'(odec_a[g]), 32'(e[11:8]));
                            check_eq($sformatf("i%0d_tag", g),    32'(otag_a[g]), 32'(e[19:12]));
                        end
                    end else if (!oval_a[g]) begin
                        check_eq($sformatf("i%0d_hold_sm", g),  32'(osm_a[g]),  32'(last_sm[g]));
                        check_eq($sformatf("i%0d_hold_dec", g), 32'(odec_a[g]), 32'(last_dec[g]));
                        check_eq($sformatf("i%0d_hold_tag", g), 32'(otag_a[g]), 32'(last_tag[g]));
                    end
                end else begin
                    check_eq($sformatf("i%0d_frz_oval", g), 32'(oval_a[g]), 32'(last_oval[g]));
                    check_eq($sformatf("i%0d_frz_sm", g),   32'(osm_a[g]),  32'(last_sm[g]));
                    check_eq($sformatf("i%0d_frz_dec", g),  32'(odec_a[g]), 32'(last_dec[g]));
                    check_eq($sformatf("i%0d_frz_tag", g),  32'(otag_a[g]), 32'(last_tag[g]));
                end
                last_oval[g] = oval_a[g];
                last_sm[g]   = osm_a[g];
                last_dec[g]  = odec_a[g];
                last_tag[g]  = otag_a[g];
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic apply(input logic v, input logic s, input logic en,
                         input logic [15:0][3:0] b, input logic [15:0][7:0] m,
                         input logic [7:0] t);
        @(negedge clk);
        #1;
        val    = v;
        sclr   = s;
        clkena = en;
        bm_v   = b;
        sm_v   = m;
        tag_v  = t;
    endtask

    task automatic idle(input int n);
        repeat (n) apply(1'b0, 1'b0, 1'b1, bm_v, sm_v, tag_v);
    endtask

    // Random set obeying the metric spread rule: all candidates lie within
    // base .. base+115 (mod 256).
    task automatic rand_set(output logic [15:0][3:0] b, output logic [15:0][7:0] m);
        int base;
        base = $urandom_range(0, 255);
        for (int i = 0; i < 16; i++) begin
            m[i] = 8'(base + $urandom_range(0, 100));
            b[i] = 4'($urandom_range(0, 15));
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [15:0][3:0] b;
        logic [15:0][7:0] m;
        int               p0;
        int               p2;
        int               p9;
        int               k;

        rst    = 1'b1;
        clkena = 1'b0;
        sclr   = 1'b0;
        val    = 1'b0;
        bm_v   = '0;
        sm_v   = '0;
        tag_v  = '0;

        #1;
        for (int g = 0; g < NI; g++) begin
            check_eq($sformatf("i%0d_rst_oval", g), 32'(oval_a[g]), 32'd0);
            check_eq($sformatf("i%0d_rst_sm", g),   32'(osm_a[g]),  32'd0);
            check_eq($sformatf("i%0d_rst_dec", g),  32'(odec_a[g]), 32'd0);
            check_eq($sformatf("i%0d_rst_tag", g),  32'(otag_a[g]), 32'd0);
        end
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;

        // 1: ascending branch metrics on equal state metrics
        for (int i = 0; i < 16; i++) begin
            b[i] = 4'(i);
            m[i] = 8'd10;
        end
        apply(1'b1, 1'b0, 1'b1, b, m, 8'h11);
        idle(8);
        check_eq("t1_statem", 32'(osm_a[0]),  32'd17);
        check_eq("t1_dec",    32'(odec_a[0]), 32'd7);
        check_eq("t1_tag",    32'(otag_a[0]), 32'h11);

        // 2: all candidates equal
        for (int i = 0; i < 16; i++) begin
            b[i] = 4'd0;
            m[i] = 8'd50;
        end
        apply(1'b1, 1'b0, 1'b1, b, m, 8'hA5);
        idle(8);
        check_eq("t2_max_dec",   32'(odec_a[0]), 32'd0);
        check_eq("t2_max_sm",    32'(osm_a[0]),  32'd50);
        check_eq("t2_max_tag",   32'(otag_a[0]), 32'hA5);
        check_eq("t2_min_dec",   32'(odec_a[1]), 32'd0);
        check_eq("t2_min_tag",   32'(otag_a[1]), 32'hA5);
        check_eq("t2_min16_dec", 32'(odec_a[9]), 32'd0);

        // 3: wrapped candidate is still the largest
        for (int i = 0; i < 16; i++) begin
            b[i] = 4'd0;
            m[i] = 8'd240;
        end
        b[3] = 4'd10;
        m[3] = 8'd250;
        apply(1'b1, 1'b0, 1'b1, b, m, 8'h33);
        idle(8);
        check_eq("t3_dec", 32'(odec_a[0]), 32'd3);
        check_eq("t3_sm",  32'(osm_a[0]),  32'd4);

        // 4: min mode, tie between the two smallest candidates
        for (int i = 0; i < 16; i++) begin
            b[i] = 4'd0;
            m[i] = 8'd20;
        end
        m[0] = 8'd30;
        m[1] = 8'd12;
        m[2] = 8'd12;
        m[3] = 8'd40;
        apply(1'b1, 1'b0, 1'b1, b, m, 8'h44);
        idle(8);
        check_eq("t4_min_dec", 32'(odec_a[1]), 32'd1);
        check_eq("t4_min_sm",  32'(osm_a[1]),  32'd12);
        check_eq("t4_max_dec", 32'(odec_a[0]), 32'd3);
        check_eq("t4_max_sm",  32'(osm_a[0]),  32'd40);

        // 5: six back-to-back sets with a clock-enable gap on the third cycle
        p0 = pop_cnt[0];
        p9 = pop_cnt[9];
        k  = 0;
        for (int c = 0; c < 7; c++) begin
            rand_set(b, m);
            apply(1'b1, 1'b0, (c != 2), b, m, 8'(8'hC0 + k));
            if (c != 2) k++;
        end
        idle(12);
        check_eq("t5_count_i0", 32'(pop_cnt[0] - p0), 32'd6);
        check_eq("t5_count_i9", 32'(pop_cnt[9] - p9), 32'd6);

        // 6: flush with a new set while two sets are in flight
        p0 = pop_cnt[0];
        p2 = pop_cnt[2];
        p9 = pop_cnt[9];
        rand_set(b, m);
        apply(1'b1, 1'b0, 1'b1, b, m, 8'hD0);
        rand_set(b, m);
        apply(1'b1, 1'b0, 1'b1, b, m, 8'hD1);
        rand_set(b, m);
        apply(1'b1, 1'b1, 1'b1, b, m, 8'hD2);
        idle(12);
        check_eq("t6_count_i0_L2", 32'(pop_cnt[0] - p0), 32'd1);
        check_eq("t6_count_i2_L1", 32'(pop_cnt[2] - p2), 32'd2);
        check_eq("t6_count_i9_L6", 32'(pop_cnt[9] - p9), 32'd0);

        // random traffic with a reset in the middle
        for (int i = 0; i < 1500; i++) begin
            if (i == 750) begin
                @(negedge clk);
                #2 rst = 1'b1;
                #1;
                check_eq("rst_mid_i0_oval", 32'(oval_a[0]), 32'd0);
                check_eq("rst_mid_i0_sm",   32'(osm_a[0]),  32'd0);
                check_eq("rst_mid_i0_tag",  32'(otag_a[0]), 32'd0);
                check_eq("rst_mid_i9_sm",   32'(osm_a[9]),  32'd0);
                check_eq("rst_mid_i9_dec",  32'(odec_a[9]), 32'd0);
                @(negedge clk);
                #2 rst = 1'b0;
            end
            rand_set(b, m);
            apply(($urandom_range(0, 9) < 7), ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 9) < 9), b, m, 8'($urandom_range(0, 255)));
        end
        idle(12);
        for (int g = 0; g < NI; g++) begin
            check_eq($sformatf("i%0d_drained", g), 32'(exp_q[g].size()), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
